// File: rtl/axis_hdr_insert_arbiter.sv
// axis_hdr_insert_arbiter: packet-level round-robin arbiter in front of a
// header inserter. One requester is granted per packet. Its header is passed
// to m_hdr_*, then its data beats are passed to m_* until the last beat.
// The source inputs are never registered; HDR and DATA are combinational
// pass-through stages.
// Optional build macro HDR_ARB_PKT_CNT_EN adds the output pkt_cnt. It holds
// one 16-bit completed-packet counter per source.
module axis_hdr_insert_arbiter #(
  parameter int NUM_SRC      = 4,
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD),
  parameter int SRC_WD       = $clog2(NUM_SRC)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_SRC-1:0]              s_hdr_valid,
  input  logic [NUM_SRC*DATA_WD-1:0]      s_hdr_data,
  input  logic [NUM_SRC*DATA_BYTE_WD-1:0] s_hdr_keep,
  input  logic [NUM_SRC*BYTE_CNT_WD-1:0]  s_hdr_cnt,
  output logic [NUM_SRC-1:0]              s_hdr_ready,
  input  logic [NUM_SRC-1:0]              s_valid,
  input  logic [NUM_SRC*DATA_WD-1:0]      s_data,
  input  logic [NUM_SRC*DATA_BYTE_WD-1:0] s_keep,
  input  logic [NUM_SRC-1:0]              s_last,
  output logic [NUM_SRC-1:0]              s_ready,
  output logic                            m_hdr_valid,
  output logic [DATA_WD-1:0]              m_hdr_data,
  output logic [DATA_BYTE_WD-1:0]         m_hdr_keep,
  output logic [BYTE_CNT_WD-1:0]          m_hdr_cnt,
  input  logic                            m_hdr_ready,
  output logic                            m_valid,
  output logic [DATA_WD-1:0]              m_data,
  output logic [DATA_BYTE_WD-1:0]         m_keep,
  output logic                            m_last,
  input  logic                            m_ready,
  output logic [NUM_SRC-1:0]              grant,
  output logic                            busy
`ifdef HDR_ARB_PKT_CNT_EN
  ,
  output logic [NUM_SRC*16-1:0]           pkt_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

  state_t              state_q, state_d;
  logic [SRC_WD-1:0]   gidx_q, gidx_d;
  logic [SRC_WD-1:0]   rr_q, rr_d;
  logic [SRC_WD-1:0]   pick_idx;
  logic                pick_found;
  logic [SRC_WD-1:0]   g_next;

  logic                    sel_hv;
  logic [DATA_WD-1:0]      sel_hd;
  logic [DATA_BYTE_WD-1:0] sel_hk;
  logic [BYTE_CNT_WD-1:0]  sel_hc;
  logic                    sel_v;
  logic [DATA_WD-1:0]      sel_d;
  logic [DATA_BYTE_WD-1:0] sel_k;
  logic                    sel_l;

  // Round-robin search: first requesting source at or after the pointer, wrapping.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int off = 0; off < NUM_SRC; off++) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (!pick_found && s_hdr_valid[i] && (((int'(rr_q) + off) % NUM_SRC) == i)) begin
          pick_found = 1'b1;
          pick_idx   = SRC_WD'(i);
        end
      end
    end
  end

  // The pointer moves to the source after the owner, wrapping from NUM_SRC-1 to 0.
  assign g_next = (gidx_q == SRC_WD'(NUM_SRC - 1)) ? '0 : gidx_q + SRC_WD'(1);

  // Select the granted source's header and data fields.
  always_comb begin
    sel_hv = 1'b0;
    sel_hd = '0;
    sel_hk = '0;
    sel_hc = '0;
    sel_v  = 1'b0;
    sel_d  = '0;
    sel_k  = '0;
    sel_l  = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (gidx_q == SRC_WD'(i)) begin
        sel_hv = s_hdr_valid[i];
        sel_hd = s_hdr_data[i*DATA_WD +: DATA_WD];
        sel_hk = s_hdr_keep[i*DATA_BYTE_WD +: DATA_BYTE_WD];
        sel_hc = s_hdr_cnt[i*BYTE_CNT_WD +: BYTE_CNT_WD];
        sel_v  = s_valid[i];
        sel_d  = s_data[i*DATA_WD +: DATA_WD];
        sel_k  = s_keep[i*DATA_BYTE_WD +: DATA_BYTE_WD];
        sel_l  = s_last[i];
      end
    end
  end

  // State, owner index and round-robin pointer registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gidx_q  <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      gidx_q  <= gidx_d;
      rr_q    <= rr_d;
    end
  end

  // Next-state logic and the outputs. Each output is zero outside the state that owns it.
  always_comb begin
    state_d     = state_q;
    gidx_d      = gidx_q;
    rr_d        = rr_q;
    m_hdr_valid = 1'b0;
    m_hdr_data  = '0;
    m_hdr_keep  = '0;
    m_hdr_cnt   = '0;
    s_hdr_ready = '0;
    m_valid     = 1'b0;
    m_data      = '0;
    m_keep      = '0;
    m_last      = 1'b0;
    s_ready     = '0;
    grant       = '0;
    busy        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          gidx_d  = pick_idx;
          state_d = HDR;
        end
      end
      HDR: begin
        busy        = 1'b1;
        grant       = NUM_SRC'(1) << gidx_q;
        m_hdr_valid = sel_hv;
        m_hdr_data  = sel_hd;
        m_hdr_keep  = sel_hk;
        m_hdr_cnt   = sel_hc;
        s_hdr_ready = NUM_SRC'(m_hdr_ready) << gidx_q;
        if (sel_hv && m_hdr_ready) state_d = DATA;
      end
      DATA: begin
        busy    = 1'b1;
        grant   = NUM_SRC'(1) << gidx_q;
        m_valid = sel_v;
        m_data  = sel_d;
        m_keep  = sel_k;
        m_last  = sel_l;
        s_ready = NUM_SRC'(m_ready) << gidx_q;
        if (sel_v && m_ready && sel_l) begin
          state_d = IDLE;
          rr_d    = g_next;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef HDR_ARB_PKT_CNT_EN
  logic [15:0] cnt_q [NUM_SRC];
  logic        pkt_done;

  assign pkt_done = (state_q == DATA) && sel_v && m_ready && sel_l;

  // Count the completed packets of each source. The count wraps at 16 bits.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SRC; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (pkt_done && (gidx_q == SRC_WD'(i))) cnt_q[i] <= cnt_q[i] + 16'd1;
      end
    end
  end

  // Pack the counters into the output bus.
  always_comb begin
    pkt_cnt = '0;
    for (int i = 0; i < NUM_SRC; i++) pkt_cnt[i*16 +: 16] = cnt_q[i];
  end
`endif

endmodule

// File: doc/axis_hdr_insert_arbiter.md
Name: axis_hdr_insert_arbiter

Overview:
- Packet-level round-robin arbiter that shares one header-insertion datapath between NUM_SRC independent requesters.
- Each requester owns a header channel and an AXI-Stream data channel.
- The arbiter grants one requester per packet and forwards its header to the inserter's header port, then its data beats until the last beat.
- Sits directly upstream of the header inserter: its m_hdr_* outputs drive the inserter's insert port, and its m_* outputs drive the inserter's data input.

Parameters:
- NUM_SRC, 4, number of requesters (2..8).
- DATA_WD, 32, data width in bits.
- DATA_BYTE_WD, DATA_WD/8, keep width.
- BYTE_CNT_WD, $clog2(DATA_BYTE_WD), header byte-count width.
- SRC_WD, $clog2(NUM_SRC), grant index width.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- s_hdr_valid  in  NUM_SRC  per-source header valid
- s_hdr_data  in  NUM_SRC*DATA_WD  packed headers, source i at [i*DATA_WD +: DATA_WD]
- s_hdr_keep  in  NUM_SRC*DATA_BYTE_WD  packed header keep
- s_hdr_cnt  in  NUM_SRC*BYTE_CNT_WD  packed header byte counts
- s_hdr_ready  out  NUM_SRC  per-source header ready
- s_valid  in  NUM_SRC  per-source data valid
- s_data  in  NUM_SRC*DATA_WD  packed data
- s_keep  in  NUM_SRC*DATA_BYTE_WD  packed keep
- s_last  in  NUM_SRC  per-source last
- s_ready  out  NUM_SRC  per-source data ready
- m_hdr_valid  out  1  header valid to inserter
- m_hdr_data  out  DATA_WD  header to inserter
- m_hdr_keep  out  DATA_BYTE_WD  header keep
- m_hdr_cnt  out  BYTE_CNT_WD  header byte count
- m_hdr_ready  in  1  inserter header ready
- m_valid  out  1  data valid to inserter
- m_data  out  DATA_WD  data to inserter
- m_keep  out  DATA_BYTE_WD  data keep
- m_last  out  1  data last
- m_ready  in  1  inserter data ready
- grant  out  NUM_SRC  one-hot current owner, 0 when idle
- busy  out  1  high in HDR or DATA state

Behaviour:
- Reset: rst_n is synchronous, active-low; clock is clk. Reset forces state IDLE, grant index 0, grant 0, RR pointer 0.
- After reset, all outputs are 0: m_hdr_valid, m_valid, m_last, s_hdr_ready, s_ready, busy, grant; data/keep/cnt outputs 0.
- Reset mid-packet abandons the packet with no flush. The owning source sees its ready drop the cycle after reset is sampled.
- FSM states:
  - IDLE: if any s_hdr_valid, pick the first set bit at or after the RR pointer (wrapping mod NUM_SRC), register the index, assert grant, go to HDR. Otherwise stay in IDLE.
  - HDR: m_hdr_* = granted source's header fields (combinational mux); s_hdr_ready[g] = m_hdr_ready; all other ready outputs 0; m_valid = 0. On m_hdr_valid & m_hdr_ready, go to DATA.
  - DATA: m_valid/m_data/m_keep/m_last = granted source's data fields; s_ready[g] = m_ready; all other s_ready and s_hdr_ready are 0; m_hdr_valid = 0. On m_valid & m_ready & m_last, go to IDLE and set RR pointer = (g+1) mod NUM_SRC.
- Latency: one IDLE cycle from s_hdr_valid to m_hdr_valid; zero-cycle combinational pass-through in HDR and DATA. Minimum packet overhead is 1 IDLE bubble.
- Data-only sources: s_valid without s_hdr_valid is never granted; its ready stays 0.
- Non-granted fields: mux outputs are forced to 0 when not in the corresponding state. Source inputs are never registered.
- RR pointer wrap: for g = NUM_SRC-1, the pointer wraps to 0.
- Simultaneous header requests are resolved by RR only. Fairness: a continuously requesting source waits at most NUM_SRC-1 packets.
- Header and last: a header handshake and a data last in the same cycle cannot occur (mutually exclusive states).
- A single-beat packet (s_last on the first beat) returns to IDLE after one DATA cycle.

Optional Feature:
- Macro: HDR_ARB_PKT_CNT_EN.
- Defined: adds output pkt_cnt, NUM_SRC*16 bits.
  - Counter i increments on each completed packet (last handshake) of source i and wraps 0xFFFF to 0.
  - Reset clears all counters to 0.
- Undefined: the port and counters are absent; all other behaviour is identical.

Test Plan:
- Single source 0: header 0xAABBCCDD, cnt 2, 3 data beats, last on beat 3 → m_hdr_valid 1 cycle after request; 3 m_valid beats identical to the inputs; grant 0001; returns to IDLE; busy low.
- All 4 sources request at once, 1-beat packets → grants in order 0001, 0010, 0100, 1000, then 0001; each packet separated by exactly 1 IDLE cycle.
- m_ready toggles 1,0,1,0 during a 4-beat packet from source 2 → s_ready[2] mirrors m_ready; m_data stable while stalled; no beats lost or duplicated.
- Source 1 holds s_valid with s_hdr_valid low while source 3 requests → only source 3 is granted; s_ready[1] stays 0 throughout.
- rst_n pulled low in DATA after beat 2 of 5 → next cycle state IDLE, all valid/ready outputs 0, grant 0; next grant starts from pointer 0.
- With HDR_ARB_PKT_CNT_EN: 3 packets from source 0, 1 from source 2 → pkt_cnt fields {0,1,0,3}, i.e. source 3..0 counts 0,1,0,3.
